// File: rtl/pixel_stream_gen.sv
// pixel_stream_gen: raster-order 8-bit test-pattern source over valid/ready.
// Revision: 1.0
`default_nettype none

module pixel_stream_gen #(
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480,
  parameter int FCNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              continuous,
  input  logic [1:0]        pattern_sel,
  output logic [7:0]        out_pixel,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_sof,
  output logic              out_eol,
  output logic              busy,
  output logic              done,
  output logic [FCNT_W-1:0] frame_count
);

  localparam int XW = $clog2(IMG_WIDTH);
  localparam int YW = $clog2(IMG_HEIGHT);
  localparam logic [XW-1:0] X_LAST = XW'(IMG_WIDTH - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(IMG_HEIGHT - 1);

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_t;

  state_t            state, state_nx;
  logic [XW-1:0]     x, x_nx;
  logic [YW-1:0]     y, y_nx;
  logic [1:0]        pat, pat_nx;
  logic [7:0]        pixel_nx;
  logic              valid_nx, sof_nx, eol_nx, busy_nx, done_nx;
  logic [FCNT_W-1:0] fcnt_nx;
  logic              xfer, last_x, last_y;

  function automatic logic [7:0] pattern_pixel(input logic [1:0]    p,
                                               input logic [XW-1:0] px,
                                               input logic [YW-1:0] py);
    logic [31:0] xe, ye;
    xe = 32'(px);
    ye = 32'(py);
    case (p)
      2'd0:    return 8'(xe + ye);
      2'd1:    return xe[7:0];
      2'd2:    return (xe[3] ^ ye[3]) ? 8'hFF : 8'h00;
      default: return 8'h80;
    endcase
  endfunction

  assign xfer   = out_valid & out_ready;
  assign last_x = (x == X_LAST);
  assign last_y = (y == Y_LAST);

  always_comb begin
    state_nx = state;
    x_nx     = x;
    y_nx     = y;
    pat_nx   = pat;
    pixel_nx = out_pixel;
    valid_nx = out_valid;
    sof_nx   = out_sof;
    eol_nx   = out_eol;
    busy_nx  = busy;
    done_nx  = 1'b0;
    fcnt_nx  = frame_count;
    case (state)
      IDLE: begin
        if (start) begin
          state_nx = STREAM;
          pat_nx   = pattern_sel;
          x_nx     = '0;
          y_nx     = '0;
          valid_nx = 1'b1;
          busy_nx  = 1'b1;
          sof_nx   = 1'b1;
          eol_nx   = 1'b0;
          pixel_nx = pattern_pixel(pattern_sel, '0, '0);
        end
      end
      STREAM: begin
        if (xfer) begin
          if (last_x && last_y) begin
            fcnt_nx = frame_count + 1'b1;
            done_nx = 1'b1;
            x_nx    = '0;
            y_nx    = '0;
            eol_nx  = 1'b0;
            // Continuous restart presents pixel (0,0) next cycle with no bubble.
            if (continuous) begin
              pat_nx   = pattern_sel;
              sof_nx   = 1'b1;
              pixel_nx = pattern_pixel(pattern_sel, '0, '0);
            end else begin
              state_nx = IDLE;
              valid_nx = 1'b0;
              busy_nx  = 1'b0;
              sof_nx   = 1'b0;
            end
          end else begin
            x_nx     = last_x ? '0 : x + 1'b1;
            y_nx     = last_x ? y + 1'b1 : y;
            sof_nx   = 1'b0;
            eol_nx   = (x_nx == X_LAST);
            pixel_nx = pattern_pixel(pat, x_nx, y_nx);
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      x           <= '0;
      y           <= '0;
      pat         <= '0;
      out_pixel   <= '0;
      out_valid   <= 1'b0;
      out_sof     <= 1'b0;
      out_eol     <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      frame_count <= '0;
    end else begin
      state       <= state_nx;
      x           <= x_nx;
      y           <= y_nx;
      pat         <= pat_nx;
      out_pixel   <= pixel_nx;
      out_valid   <= valid_nx;
      out_sof     <= sof_nx;
      out_eol     <= eol_nx;
      busy        <= busy_nx;
      done        <= done_nx;
      frame_count <= fcnt_nx;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_pixel_stream_gen.sv
// tb_pixel_stream_gen: two pixel_stream_gen instances (4x2 and 16x16) checked
// cycle by cycle against a frame-index reference model.
`default_nettype none

module tb_pixel_stream_gen;

  localparam int WA = 4;
  localparam int HA = 2;
  localparam int WB = 16;
  localparam int HB = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        start [2];
  logic        cont  [2];
  logic        ready [2];
  logic [1:0]  psel  [2];
  logic [7:0]  pix   [2];
  logic        valid [2];
  logic        sof   [2];
  logic        eol   [2];
  logic        busy  [2];
  logic        done  [2];
  logic [15:0] fc    [2];

  // Reference model: active flag, linear pixel index within frame, pattern, frame count.
  int m_act [2];
  int m_p   [2];
  int m_pat [2];
  int m_fc  [2];
  int m_done[2];
  int xfers [2];

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pixel_stream_gen #(.IMG_WIDTH(WA), .IMG_HEIGHT(HA), .FCNT_W(16)) dut_a (
    .clk(clk), .rst(rst), .start(start[0]), .continuous(cont[0]), .pattern_sel(psel[0]),
    .out_pixel(pix[0]), .out_valid(valid[0]), .out_ready(ready[0]), .out_sof(sof[0]),
    .out_eol(eol[0]), .busy(busy[0]), .done(done[0]), .frame_count(fc[0]));

  pixel_stream_gen #(.IMG_WIDTH(WB), .IMG_HEIGHT(HB), .FCNT_W(16)) dut_b (
    .clk(clk), .rst(rst), .start(start[1]), .continuous(cont[1]), .pattern_sel(psel[1]),
    .out_pixel(pix[1]), .out_valid(valid[1]), .out_ready(ready[1]), .out_sof(sof[1]),
    .out_eol(eol[1]), .busy(busy[1]), .done(done[1]), .frame_count(fc[1]));

  task automatic chk(input string tag, input int obs, input int exp);
    n_vec++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", tag, obs, obs, exp, exp, $time);
    end
  endtask

  function automatic int ref_pix(input int pat, input int x, input int y);
    case (pat)
      0:       return (x + y) % 256;
      1:       return x % 256;
      2:       return (((x / 8) + (y / 8)) % 2 == 1) ? 255 : 0;
      default: return 128;
    endcase
  endfunction

  function automatic int width_of(input int i);
    return (i == 0) ? WA : WB;
  endfunction

  function automatic int height_of(input int i);
    return (i == 0) ? HA : HB;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_act[i] = 0; m_p[i] = 0; m_pat[i] = 0; m_fc[i] = 0; m_done[i] = 0;
    end
  endtask

  task automatic compare_all();
    for (int i = 0; i < 2; i++) begin
      automatic int w = width_of(i);
      chk($sformatf("valid%0d", i), int'(valid[i]), m_act[i]);
      chk($sformatf("busy%0d", i),  int'(busy[i]),  m_act[i]);
      chk($sformatf("sof%0d", i),   int'(sof[i]),   (m_act[i] != 0 && m_p[i] == 0) ? 1 : 0);
      chk($sformatf("eol%0d", i),   int'(eol[i]),   (m_act[i] != 0 && m_p[i] % w == w - 1) ? 1 : 0);
      chk($sformatf("done%0d", i),  int'(done[i]),  m_done[i]);
      chk($sformatf("fcnt%0d", i),  int'(fc[i]),    m_fc[i]);
      if (m_act[i] != 0)
        chk($sformatf("pixel%0d", i), int'(pix[i]), ref_pix(m_pat[i], m_p[i] % w, m_p[i] / w));
    end
  endtask

  // Advance the model by one clock using the inputs as they stand before the edge,
  // then clock the DUTs and compare just after the edge.
  task automatic step();
    for (int i = 0; i < 2; i++) begin
      automatic int n = width_of(i) * height_of(i);
      if (valid[i] && ready[i]) xfers[i]++;
      m_done[i] = 0;
      if (m_act[i] == 0) begin
        if (start[i]) begin
          m_act[i] = 1; m_p[i] = 0; m_pat[i] = int'(psel[i]);
        end
      end else if (ready[i]) begin
        if (m_p[i] == n - 1) begin
          m_fc[i]   = (m_fc[i] + 1) % 65536;
          m_done[i] = 1;
          if (cont[i]) begin
            m_p[i] = 0; m_pat[i] = int'(psel[i]);
          end else begin
            m_act[i] = 0;
          end
        end else begin
          m_p[i]++;
        end
      end
    end
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic run_until_idle(input int i, input int bound);
    automatic int k = 0;
    while (busy[i] && k < bound) begin
      step();
      k++;
    end
    chk($sformatf("idle_timeout%0d", i), int'(busy[i]), 0);
  endtask

  task automatic pulse_start(input int i, input int pat);
    psel[i]  = 2'(pat);
    start[i] = 1'b1;
    step();
    start[i] = 1'b0;
  endtask

  initial begin
    int fc0;
    int dones;
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      start[i] = 1'b0; cont[i] = 1'b0; ready[i] = 1'b0; psel[i] = 2'd0; xfers[i] = 0;
    end
    model_reset();
    #12;
    for (int i = 0; i < 2; i++) begin
      chk("rst_valid", int'(valid[i]), 0);
      chk("rst_busy",  int'(busy[i]),  0);
      chk("rst_sof",   int'(sof[i]),   0);
      chk("rst_eol",   int'(eol[i]),   0);
      chk("rst_done",  int'(done[i]),  0);
      chk("rst_fcnt",  int'(fc[i]),    0);
      chk("rst_pixel", int'(pix[i]),   0);
    end
    rst = 1'b0;

    // Ramp frame at full throughput on the 4x2 instance.
    ready[0] = 1'b1;
    pulse_start(0, 0);
    run(10);
    chk("ramp_fcnt", int'(fc[0]), 1);

    // Random backpressure: exactly one frame's worth of transfers.
    xfers[0] = 0;
    pulse_start(0, 0);
    for (int k = 0; k < 200 && busy[0]; k++) begin
      ready[0] = 1'($urandom_range(0, 1));
      step();
    end
    chk("bp_transfers", xfers[0], WA * HA);
    chk("bp_idle", int'(busy[0]), 0);
    ready[0] = 1'b1;

    // Checkerboard on the 16x16 instance.
    ready[1] = 1'b1;
    xfers[1] = 0;
    pulse_start(1, 2);
    run_until_idle(1, 400);
    chk("cb_transfers", xfers[1], WB * HB);

    // Continuous mode, pattern 3; drop continuous during the third frame.
    fc0 = int'(fc[1]);
    dones = 0;
    cont[1] = 1'b1;
    pulse_start(1, 3);
    for (int k = 0; k < 2000 && dones < 2; k++) begin
      step();
      if (done[1]) dones++;
    end
    run(20);
    cont[1] = 1'b0;
    run_until_idle(1, 1000);
    chk("cont_frames", int'(fc[1]) - fc0, 3);

    // Start and pattern change mid-frame are ignored.
    pulse_start(0, 0);
    run(2);
    start[0] = 1'b1;
    psel[0]  = 2'd1;
    step();
    start[0] = 1'b0;
    run_until_idle(0, 50);

    // Asynchronous reset mid-frame on both instances.
    pulse_start(0, 0);
    pulse_start(1, 0);
    run(5);
    #2;
    rst = 1'b1;
    #1;
    for (int i = 0; i < 2; i++) begin
      chk("arst_valid", int'(valid[i]), 0);
      chk("arst_busy",  int'(busy[i]),  0);
      chk("arst_fcnt",  int'(fc[i]),    0);
    end
    model_reset();
    rst = 1'b0;
    pulse_start(0, 0);
    run_until_idle(0, 50);
    chk("arst_refcnt", int'(fc[0]), 1);

    // Randomized traffic on both instances.
    for (int k = 0; k < 600; k++) begin
      for (int i = 0; i < 2; i++) begin
        start[i] = ($urandom_range(0, 3) == 0);
        cont[i]  = ($urandom_range(0, 2) == 0);
        ready[i] = ($urandom_range(0, 3) != 0);
        psel[i]  = 2'($urandom_range(0, 3));
      end
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/pixel_stream_gen.md
Name: pixel_stream_gen

Overview:
Test-pattern pixel source feeding the HOG core input stream. It sits directly upstream of the HOG core. Its out_pixel/out_valid and the core's ready drive the hog_input_valid, hog_input_ready and input_pixels status taps. It produces raster-order 8-bit frames over a valid/ready handshake, one frame per start or back-to-back in continuous mode, and keeps a frame counter for PIO readback.

Parameters:
IMG_WIDTH, 640, pixels per line (>= 2)
IMG_HEIGHT, 480, lines per frame (>= 2)
FCNT_W, 16, width of frame_count

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
start  in  1  single-cycle request to begin a frame; honoured only in IDLE
continuous  in  1  sampled at end of each frame; 1 = start next frame immediately
pattern_sel  in  2  pattern select, latched at start and at each continuous restart
out_pixel  out  8  pixel value
out_valid  out  1  pixel valid
out_ready  in  1  downstream (HOG core) ready
out_sof  out  1  high with pixel (0,0)
out_eol  out  1  high with last pixel of each line (x == IMG_WIDTH-1)
busy  out  1  high in STREAM state
done  out  1  one-cycle pulse after last pixel of a frame is accepted
frame_count  out  FCNT_W  completed frames, wraps modulo 2^FCNT_W

Behaviour:
- Reset: state IDLE; x, y, frame_count = 0; out_valid, out_sof, out_eol, busy, done = 0; out_pixel = 0; latched pattern = 0.
- All outputs registered. Counters: x is $clog2(IMG_WIDTH) bits, y is $clog2(IMG_HEIGHT) bits.
- Transfer = out_valid & out_ready on a rising clk edge.
- States: IDLE, STREAM.
- IDLE -> STREAM: start=1 sampled at edge N. At N, latch pattern_sel and set x=y=0. From N+1: out_valid=1, busy=1, out_sof=1, pixel(0,0) on out_pixel.
- start is ignored in STREAM.
- Handshake rules: while out_valid=1 and out_ready=0, out_pixel, out_sof and out_eol hold stable. out_valid never drops until transfer. out_valid never depends combinationally on out_ready.
- On transfer, advance: x+1. At x == IMG_WIDTH-1, x=0 and y+1. The next pixel is presented the cycle after the transfer, so throughput is 1 pixel/clk with out_ready held high.
- Last transfer, at x=IMG_WIDTH-1 and y=IMG_HEIGHT-1:
  - frame_count+1, wrapping; done=1 for the next cycle only.
  - If continuous=1 at that edge: stay in STREAM, x=y=0, re-latch pattern_sel, next cycle presents pixel(0,0) with out_sof=1. No bubble.
  - Otherwise go to IDLE: out_valid=0, busy=0.
- start asserted on the same edge as a final transfer (non-continuous) is ignored. A new start is required after IDLE is reached.
- Patterns, with x and y being current pixel coordinates:
  - 0 ramp: (x + y) mod 256
  - 1 horizontal gradient: x[7:0]
  - 2 checkerboard 8x8: 8'hFF if x[3] ^ y[3], else 8'h00
  - 3 constant: 8'h80
- pattern_sel changes mid-frame have no effect.
- Reset mid-frame: immediate return to reset values. The partial frame is not counted, and no done pulse is issued.
- continuous deasserted mid-frame: the current frame completes, then the block goes to IDLE.

Test Plan:
- Ramp frame: IMG_WIDTH=4, IMG_HEIGHT=2, pattern 0, start pulse, out_ready=1 -> pixels 0,1,2,3,1,2,3,4 on 8 consecutive cycles starting 1 cycle after start. out_sof on the first pixel, out_eol on pixels 4 and 8. done pulses once the cycle after the last pixel; frame_count=1; busy falls.
- Backpressure: same frame with out_ready toggling 1,0,0,1,... -> out_pixel, out_valid and flags stay stable during ready=0. Exactly 8 transfers with an identical value sequence.
- Checkerboard: IMG_WIDTH=16, IMG_HEIGHT=16, pattern 2 -> pixel(0,0)=0x00, (8,0)=0xFF, (0,8)=0xFF, (8,8)=0x00. 256 transfers, then done.
- Continuous mode: continuous=1, pattern 3, 3 frames -> 3 done pulses, 3×W×H contiguous transfers with no out_valid gap. Drop continuous during frame 3 -> IDLE after it; frame_count=3.
- Start while busy / pattern change mid-frame: start pulsed and pattern_sel changed at pixel 3 of a ramp frame -> stream unaffected, still ramp values, no restart.
- Async reset at pixel 5: rst asserted mid-cycle -> out_valid, busy and frame_count go to 0 immediately. A later start yields a full frame from pixel(0,0) with frame_count=1 at its end.
